// File: rtl/fp32_serial_host.sv
`default_nettype none
// ============================================================================
// Module  : fp32_serial_host
// Brief   : Host driver for the bit-serial add_float adder. It serializes two
//           FP32 operands, collects the serial sum and returns it with flags.
// Revision: 1.0 - initial release
// ============================================================================
module fp32_serial_host #(
  parameter int TIMEOUT  = 60,
  parameter int RES_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_c,
  output logic        rsp_over,
  output logic        rsp_under,
  output logic        rsp_err,
  output logic        go,
  output logic        inpab,
  input  logic        shift,
  input  logic        out_c,
  input  logic        over,
  input  logic        under,
  input  logic        done
);

  localparam int C_WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_go_nxt;
  logic                w_inpab_nxt;
  logic [63:0]         r_sreg;
  logic [5:0]          r_bit_cnt;
  logic [C_WAIT_W-1:0] r_wait_cnt;
  logic [31:0]         r_cap;
  logic [5:0]          r_cap_cnt;
  logic [31:0]         w_cap_shifted;
  logic [5:0]          w_cap_cnt_inc;
  logic [6:0]          w_cap_cnt_final;
  logic                w_timeout;
  logic                w_capture;

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);

  assign w_cap_shifted   = {r_cap[30:0], out_c};
  assign w_cap_cnt_inc   = (r_cap_cnt == 6'd63) ? 6'd63 : r_cap_cnt + 6'd1;
  // A shift arriving together with done counts towards the final bit total.
  assign w_cap_cnt_final = {1'b0, r_cap_cnt} + {6'd0, shift};
  assign w_timeout       = (r_wait_cnt == C_WAIT_W'(TIMEOUT - 1));
  assign w_capture       = shift && ((r_state == S_SEND) || (r_state == S_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      go      <= 1'b1;
      inpab   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      go      <= w_go_nxt;
      inpab   <= w_inpab_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go_nxt    = 1'b1;
    w_inpab_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = S_START;
          w_go_nxt    = 1'b0;
        end
      end
      S_START: begin
        w_state_nxt = S_SEND;
        w_inpab_nxt = r_sreg[63];
      end
      S_SEND: begin
        if (done) begin
          w_state_nxt = S_RESP;
        end else if (r_bit_cnt == 6'd63) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_inpab_nxt = r_sreg[63];
        end
      end
      S_WAIT: begin
        if (done || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sreg     <= '0;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      r_cap      <= '0;
      r_cap_cnt  <= '0;
      rsp_c      <= '0;
      rsp_over   <= 1'b0;
      rsp_under  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_cap     <= w_cap_shifted;
        r_cap_cnt <= w_cap_cnt_inc;
      end
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_sreg     <= {op_a, op_b};
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_cap      <= '0;
            r_cap_cnt  <= '0;
          end
        end
        S_START: begin
          r_sreg <= {r_sreg[62:0], 1'b0};
        end
        S_SEND: begin
          if (done) begin
            // Adder finished before it could have seen both operands.
            rsp_c     <= r_cap;
            rsp_over  <= 1'b0;
            rsp_under <= 1'b0;
            rsp_err   <= 1'b1;
          end else begin
            r_sreg    <= {r_sreg[62:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 6'd1;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + C_WAIT_W'(1);
          if (done) begin
            rsp_c     <= shift ? w_cap_shifted : r_cap;
            rsp_over  <= over;
            rsp_under <= under;
            rsp_err   <= (w_cap_cnt_final != 7'(RES_BITS));
          end else if (w_timeout) begin
            rsp_c     <= '0;
            rsp_over  <= 1'b0;
            rsp_under <= 1'b0;
            rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp32_serial_host.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp32_serial_host
// Brief   : Directed scoreboard bench for fp32_serial_host with an adder model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fp32_serial_host;

  localparam int TIMEOUT = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_c;
  logic        rsp_over;
  logic        rsp_under;
  logic        rsp_err;
  logic        go;
  logic        inpab;
  logic        shift = 1'b0;
  logic        out_c = 1'b0;
  logic        over = 1'b0;
  logic        under = 1'b0;
  logic        done = 1'b0;

  fp32_serial_host #(.TIMEOUT(TIMEOUT), .RES_BITS(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .op_a(op_a), .op_b(op_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .rsp_over(rsp_over), .rsp_under(rsp_under), .rsp_err(rsp_err),
    .go(go), .inpab(inpab), .shift(shift), .out_c(out_c),
    .over(over), .under(under), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] c;
    logic        ov;
    logic        un;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] c, input logic ov, input logic un, input logic err);
    rsp_t e;
    e.c = c; e.ov = ov; e.un = un; e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per response handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_c",     64'(rsp_c),     64'(e.c));
          chk("rsp_over",  64'(rsp_over),  64'(e.ov));
          chk("rsp_under", 64'(rsp_under), 64'(e.un));
          chk("rsp_err",   64'(rsp_err),   64'(e.err));
        end
      end
    end
  end

  // Issue one request and play the adder. mode: 0 = done after bits,
  // 1 = done together with the last bit, 2 = never done (timeout).
  task automatic xfer(input logic [31:0] a, input logic [31:0] b, input int nbits,
                      input logic [31:0] res, input logic ov, input logic un,
                      input int mode, input bit keep_valid, input int abort_bit);
    logic [63:0] got;
    int cyc;
    got = '0;
    req_valid = 1'b1; op_a = a; op_b = b;
    cyc = 0;
    while (go !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("go_fall", 64'(go), 64'd0);
    if (go !== 1'b0) begin
      req_valid = 1'b0;
      return;
    end
    if (!keep_valid) req_valid = 1'b0;
    @(negedge clk);
    chk("go_pulse_one_cycle", 64'(go), 64'd1);
    for (int i = 0; i < 64; i++) begin
      if (i == abort_bit) begin
        #2 reset = 1'b0;
        #1;
        chk("rst_go",        64'(go),        64'd1);
        chk("rst_inpab",     64'(inpab),     64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        return;
      end
      got = {got[62:0], inpab};
      if (i != 63) @(negedge clk);
    end
    chk("inpab_seq", got, {a, b});
    @(negedge clk);
    if (mode == 2) begin
      cyc = 0;
      while (!rsp_valid && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk("timeout_latency", 64'(cyc), 64'(TIMEOUT));
      return;
    end
    for (int i = 0; i < nbits; i++) begin
      shift = 1'b1;
      out_c = res[31-i];
      if (mode == 1 && i == nbits - 1) begin
        done = 1'b1; over = ov; under = un;
      end
      @(negedge clk);
    end
    shift = 1'b0; out_c = 1'b0;
    if (mode == 0) begin
      done = 1'b1; over = ov; under = un;
      @(negedge clk);
    end
    done = 1'b0; over = 1'b0; under = 1'b0;
  endtask

  localparam logic [31:0] A   = 32'h0378_0000;
  localparam logic [31:0] B   = 32'h8278_0000;
  localparam logic [31:0] SUM = 32'h033A_0000;

  initial begin
    logic [34:0] snap;
    int cyc;
    bit stable;
    bit quiet;

    // Reset
    #100;
    chk("reset_go",        64'(go),        64'd1);
    chk("reset_inpab",     64'(inpab),     64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp",       64'({rsp_valid, rsp_c, rsp_over, rsp_under, rsp_err}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 64'({go, inpab, req_ready, rsp_valid}), 64'b1010);

    // Normal transfer
    push_exp(SUM, 1'b0, 1'b0, 1'b0);
    xfer(A, B, 32, SUM, 1'b0, 1'b0, 0, 1'b0, -1);
    repeat (3) @(negedge clk);

    // Backpressure with req_valid held
    rsp_ready = 1'b0;
    push_exp(SUM, 1'b0, 1'b1, 1'b0);
    xfer(A, B, 32, SUM, 1'b0, 1'b1, 0, 1'b1, -1);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    snap = {rsp_c, rsp_over, rsp_under, rsp_err};
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({rsp_c, rsp_over, rsp_under, rsp_err} !== snap || rsp_valid !== 1'b1 ||
          req_ready !== 1'b0 || go !== 1'b1) stable = 1'b0;
    end
    chk("bp_hold_stable", 64'(stable), 64'd1);
    rsp_ready = 1'b1;
    // req_valid is still high: the second request starts right after the handshake.
    push_exp(SUM, 1'b0, 1'b0, 1'b0);
    xfer(A, B, 32, SUM, 1'b0, 1'b0, 0, 1'b0, -1);
    repeat (3) @(negedge clk);

    // Timeout
    push_exp(32'h0, 1'b0, 1'b0, 1'b1);
    xfer(A, B, 0, SUM, 1'b0, 1'b0, 2, 1'b0, -1);
    repeat (3) @(negedge clk);

    // Short result: 31 bits then done with over
    push_exp(32'h019D_0000, 1'b1, 1'b0, 1'b1);
    xfer(A, B, 31, SUM, 1'b1, 1'b0, 0, 1'b0, -1);
    repeat (3) @(negedge clk);

    // 32nd bit arrives in the same cycle as done
    push_exp(32'h1234_5679, 1'b1, 1'b0, 1'b0);
    xfer(32'h3F80_0000, 32'h4000_0000, 32, 32'h1234_5679, 1'b1, 1'b0, 1, 1'b0, -1);
    repeat (3) @(negedge clk);

    // Reset in the middle of SEND
    xfer(A, B, 32, SUM, 1'b0, 1'b0, 0, 1'b0, 20);
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || go !== 1'b1) quiet = 1'b0;
    end
    chk("no_rsp_after_reset", 64'(quiet), 64'd1);
    push_exp(SUM, 1'b0, 1'b0, 1'b0);
    xfer(A, B, 32, SUM, 1'b0, 1'b0, 0, 1'b0, -1);
    repeat (5) @(negedge clk);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
